serial_comp: RTL and testbench

- Sequential wide-magnitude comparator built around one instance of the team's 4-bit cascade slice, comp_4.
- Accepts two WIDTH-bit operands through a valid/ready handshake.
- Walks the operands one nibble per cycle, least-significant nibble first. Each cycle the slice's gt/eq/lt outputs are registered and fed back as its last_gt/last_eq/last_lt inputs.
- Sits directly upstream of comp_4: it sequences the slice's operands and cascade inputs, then presents the final relation to a downstream consumer.

---
 rtl/serial_comp.sv | 142 ++++++++++++++
 tb/tb_serial_comp.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comp.sv
// Sequential WIDTH-bit magnitude comparator that walks the operands one nibble
// per cycle, LSB nibble first, through a single comp_4 cascade slice.

module comp_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       last_gt,
    input  logic       last_eq,
    input  logic       last_lt,
    output logic       gt,
    output logic       eq,
    output logic       lt
);
    always_comb begin
        gt = last_gt;
        eq = last_eq;
        lt = last_lt;
        if (a > b) begin
            gt = 1'b1;
            eq = 1'b0;
            lt = 1'b0;
        end else if (a < b) begin
            gt = 1'b0;
            eq = 1'b0;
            lt = 1'b1;
        end
    end
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble compared per cycle, flags fed back as cascade inputs
// DONE  | result presented until the consumer takes it
module serial_comp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("serial_comp: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             sgn;
    logic [CW-1:0]    cnt;
    logic             flag_gt;
    logic             flag_eq;
    logic             flag_lt;
    logic             last;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic             s_gt;
    logic             s_eq;
    logic             s_lt;

    assign last = (cnt == CW'(N - 1));

    // Flipping the sign bit of the top nibble maps two's-complement order onto unsigned order.
    assign nib_a = sh_a[3:0] ^ {sgn & last, 3'b000};
    assign nib_b = sh_b[3:0] ^ {sgn & last, 3'b000};

    comp_4 u_slice (
        .a       (nib_a),
        .b       (nib_b),
        .last_gt (flag_gt),
        .last_eq (flag_eq),
        .last_lt (flag_lt),
        .gt      (s_gt),
        .eq      (s_eq),
        .lt      (s_lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            sgn     <= 1'b0;
            cnt     <= '0;
            flag_gt <= 1'b0;
            flag_eq <= 1'b1;
            flag_lt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_a    <= a;
                        sh_b    <= b;
                        sgn     <= is_signed;
                        cnt     <= '0;
                        flag_gt <= 1'b0;
                        flag_eq <= 1'b1;
                        flag_lt <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    flag_gt <= s_gt;
                    flag_eq <= s_eq;
                    flag_lt <= s_lt;
                    sh_a    <= sh_a >> 4;
                    sh_b    <= sh_b >> 4;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is qualified by rst_n so nothing is accepted while reset is asserted.
    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign gt        = flag_gt & out_valid;
    assign eq        = flag_eq & out_valid;
    assign lt        = flag_lt & out_valid;
endmodule

// File: tb/tb_serial_comp.sv
// Scoreboard bench for serial_comp (WIDTH=16): expected relations are queued at
// accept time from a reference model and compared when the result is presented.

module tb_serial_comp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        gt;
    logic        eq;
    logic        lt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [2:0] exp_q[$];

    serial_comp #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        if (s) begin
            if ($signed(x) > $signed(y)) return 3'b100;
            if ($signed(x) < $signed(y)) return 3'b001;
            return 3'b010;
        end
        if (x > y) return 3'b100;
        if (x < y) return 3'b001;
        return 3'b010;
    endfunction

    // Waits for in_ready, then presents one operand pair for a single edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s, input bit push);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total_cnt++;
        if (in_ready !== 1'b1) begin
            $display("FAIL send_wait_ready in_ready=%b required 1", in_ready);
        end else begin
            pass_cnt++;
            a = x; b = y; is_signed = s; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (push) exp_q.push_back(model(x, y, s));
            // Scramble inputs to show captured operands are independent of later changes.
            a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
        end
    endtask

    task automatic wait_out(output int cyc, output bit leak);
        cyc = 0;
        leak = 1'b0;
        while (!out_valid && cyc < 20) begin
            if ((gt | eq | lt) !== 1'b0) leak = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({in_ready, out_valid, gt, eq, lt} !== 5'b0) begin
            $display("FAIL reset_outputs got rdy/ov/gt/eq/lt=%b required 00000", {in_ready, out_valid, gt, eq, lt});
        end else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b required 1", in_ready);
        else pass_cnt++;
    endtask

    // Runs one scored operation end to end with latency, idle-zero and result checks.
    task automatic scored_op(input string name, input logic [15:0] x, input logic [15:0] y, input logic s);
        int cyc;
        bit leak;
        logic [2:0] exp_r;
        send(x, y, s, 1'b1);
        wait_out(cyc, leak);
        total_cnt++;
        if (cyc !== 4) $display("FAIL %s_latency got %0d required 4", name, cyc);
        else pass_cnt++;
        total_cnt++;
        if (leak !== 1'b0) $display("FAIL %s_idle_flags got nonzero flags required 0 while out_valid=0", name);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s_scoreboard got empty queue required 1 entry", name);
        end else begin
            exp_r = exp_q.pop_front();
            if ({gt, eq, lt} !== exp_r) $display("FAIL %s_result got %b required %b", name, {gt, eq, lt}, exp_r);
            else pass_cnt++;
        end
        handshake();
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL %s_after_hs got ov/rdy=%b required 01", name, {out_valid, in_ready});
        else pass_cnt++;
    endtask

    task automatic test_equal();
        scored_op("equal_u", 16'h1234, 16'h1234, 1'b0);
    endtask

    task automatic test_msb_override();
        scored_op("msb_lt", 16'h0FFF, 16'h1000, 1'b0);
        scored_op("lsb_gt", 16'h1235, 16'h1234, 1'b0);
    endtask

    task automatic test_signed();
        scored_op("s_neg1_vs_1", 16'hFFFF, 16'h0001, 1'b1);
        scored_op("u_ffff_vs_1", 16'hFFFF, 16'h0001, 1'b0);
        scored_op("s_min_vs_max", 16'h8000, 16'h7FFF, 1'b1);
    endtask

    task automatic test_backpressure();
        int cyc;
        bit leak;
        logic [2:0] exp_r;
        bit bad;
        send(16'h0005, 16'h0003, 1'b0, 1'b1);
        wait_out(cyc, leak);
        exp_r = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000;
        total_cnt++;
        if (exp_r !== 3'b100) $display("FAIL bp_scoreboard got %b required 100", exp_r);
        else pass_cnt++;
        a = 16'h0000; b = 16'h0001; is_signed = 1'b0; in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({out_valid, in_ready, gt, eq, lt} !== {2'b10, exp_r}) begin
                bad = 1'b1;
                $display("FAIL bp_hold_cycle%0d got ov/rdy/gel=%b required %b", i, {out_valid, in_ready, gt, eq, lt}, {2'b10, exp_r});
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (bad) $display("FAIL bp_hold got unstable required stable");
        else pass_cnt++;
        in_valid = 1'b0;
        handshake();
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_after_hs got ov/rdy=%b required 01", {out_valid, in_ready});
        else pass_cnt++;
        total_cnt++;
        if ({gt, eq, lt} !== 3'b000) $display("FAIL bp_no_stale got %b required 000", {gt, eq, lt});
        else pass_cnt++;
        scored_op("bp_next", 16'h0000, 16'h0001, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        send(16'h1000, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL midrst_release got ov/rdy=%b required 01", {out_valid, in_ready});
        else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid || gt) seen = 1'b1;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (seen) $display("FAIL midrst_no_result got stale output required none");
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa[4] = '{16'h8000, 16'h8000, 16'h7FFF, 16'hABCD};
        logic [15:0] ob[4] = '{16'h0001, 16'h0001, 16'h7FFF, 16'hABCE};
        logic        os[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int k = 0, pops = 0, cyc = 0, last_acc = -1;
        bit acc, hs;
        logic [2:0] got, exp_r;
        out_ready = 1'b1;
        while (pops < 4 && cyc < 80) begin
            if (k < 4) begin
                a = oa[k]; b = ob[k]; is_signed = os[k]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            got = {gt, eq, lt};
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                exp_q.push_back(model(oa[k], ob[k], os[k]));
                if (last_acc >= 0) begin
                    total_cnt++;
                    if (cyc - last_acc !== 6) $display("FAIL b2b_interval%0d got %0d required 6", k, cyc - last_acc);
                    else pass_cnt++;
                end
                last_acc = cyc;
                k++;
            end
            if (hs) begin
                exp_r = exp_q.pop_front();
                total_cnt++;
                if (got !== exp_r) $display("FAIL b2b_result%0d got %b required %b", pops, got, exp_r);
                else pass_cnt++;
                pops++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total_cnt++;
        if (pops !== 4) $display("FAIL b2b_timeout got %0d results required 4", pops);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb_override();
        test_signed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
